// File: rtl/echo_timer_pkg.sv
// ---------------------------------------------------------------------------
// echo_timer_pkg
//
// Shared definitions for the echo timer and the control FSM that drives it.
// The control FSM imports the same default constants so both sides agree on
// trigger length, blanking window, timeout and counter width.
//
// Contents:
//   state_t           - measurement state encoding
//   DEF_*             - default parameter values
// ---------------------------------------------------------------------------
package echo_timer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_TRIG   = 3'd1,
      ST_BLANK  = 3'd2,
      ST_LISTEN = 3'd3,
      ST_REPORT = 3'd4
   } state_t;

   localparam int DEF_WIDTH       = 16;
   localparam int DEF_TRIG_LEN    = 10;
   localparam int DEF_BLANK_LEN   = 20;
   localparam int DEF_TIMEOUT     = 60000;
   localparam int DEF_SYNC_STAGES = 2;

endpackage : echo_timer_pkg

// File: rtl/echo_timer_sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
//
// Plain multi-flop synchronizer for a single asynchronous level. All stages
// clear to 0 on reset so that a freshly released block sees a low level.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   d        in   asynchronous input level
//   q        out  synchronized level, SYNC_STAGES cycles of latency
// ---------------------------------------------------------------------------
module sync_chain #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] r_sync;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour, giving a true shift chain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], d};
      end
   end

   assign q = r_sync[SYNC_STAGES-1];

endmodule : sync_chain

// File: rtl/echo_timer.sv
// ---------------------------------------------------------------------------
// echo_timer
//
// Launches a trigger pulse, ignores the echo input for a blanking window,
// then measures how many clk cycles pass until the echo rises. The result is
// latched on count and flagged with a one-cycle done pulse, or with a
// one-cycle timeout pulse (count = TIMEOUT) if no echo arrives in time.
//
// Ports:
//   clk      in   system clock, all state on the rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   measurement request, only looked at while idle
//   echo_in  in   asynchronous echo level from the pin
//   trigger  out  outgoing pulse, high for TRIG_LEN cycles
//   busy     out  high whenever a measurement is in progress
//   done     out  one-cycle pulse, valid echo measured
//   timeout  out  one-cycle pulse, no echo before TIMEOUT
//   count    out  latched result, held until the next done/timeout
// ---------------------------------------------------------------------------
module echo_timer
   import echo_timer_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int TRIG_LEN    = DEF_TRIG_LEN,
   parameter int BLANK_LEN   = DEF_BLANK_LEN,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             echo_in,
   output logic             trigger,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [WIDTH-1:0] count
);

   // Counter values at which each phase ends (cnt value seen in the last
   // cycle of that phase).
   localparam logic [WIDTH-1:0] TRIG_LAST  = WIDTH'(TRIG_LEN - 1);
   localparam logic [WIDTH-1:0] BLANK_LAST = WIDTH'(TRIG_LEN + BLANK_LEN - 1);
   localparam logic [WIDTH-1:0] TO_LAST    = WIDTH'(TIMEOUT - 1);
   localparam logic [WIDTH-1:0] TO_VALUE   = WIDTH'(TIMEOUT);
   localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nxt;
   logic             r_trigger;
   logic             w_trigger_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             r_timeout;
   logic             w_timeout_nxt;

   logic             w_es;
   logic             r_prev;
   logic             w_edge;

   // ------------------------------------------------------------------
   // Echo path: synchronize, then detect a rising edge. r_prev follows the
   // synchronized level in every state, so a level that is already high
   // when listening starts never looks like an edge.
   // ------------------------------------------------------------------
   sync_chain #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (echo_in),
      .q       (w_es)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= w_es;
      end
   end

   assign w_edge = w_es & ~r_prev;

   // ------------------------------------------------------------------
   // State register, counter and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_count   <= '0;
         r_trigger <= 1'b0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_count   <= w_count_nxt;
         r_trigger <= w_trigger_nxt;
         r_done    <= w_done_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_count_nxt   = r_count;
      w_done_nxt    = 1'b0;
      w_timeout_nxt = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_TRIG;
               w_cnt_nxt   = '0;
            end
         end

         ST_TRIG: begin
            w_cnt_nxt = r_cnt + CNT_ONE;
            if (r_cnt == TRIG_LAST) begin
               // With no blanking window the echo is watched straight away.
               w_state_nxt = (BLANK_LEN == 0) ? ST_LISTEN : ST_BLANK;
            end
         end

         ST_BLANK: begin
            w_cnt_nxt = r_cnt + CNT_ONE;
            if (r_cnt == BLANK_LAST) begin
               w_state_nxt = ST_LISTEN;
            end
         end

         ST_LISTEN: begin
            // An echo in the last listening cycle still counts: it is
            // checked before the timeout condition. cnt is frozen on exit so
            // it never goes past TIMEOUT-1.
            if (w_edge) begin
               w_count_nxt = r_cnt;
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_REPORT;
            end else if (r_cnt == TO_LAST) begin
               w_count_nxt   = TO_VALUE;
               w_timeout_nxt = 1'b1;
               w_state_nxt   = ST_REPORT;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end

         ST_REPORT: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Trigger is registered so the pin sees a clean, glitch-free level.
      w_trigger_nxt = (w_state_nxt == ST_TRIG);
   end

   assign trigger = r_trigger;
   assign busy    = (r_state != ST_IDLE);
   assign done    = r_done;
   assign timeout = r_timeout;
   assign count   = r_count;

endmodule : echo_timer

// File: tb/tb_echo_timer.sv
// ---------------------------------------------------------------------------
// tb_echo_timer
//
// Directed bench for echo_timer. A timeline model predicts every output from
// the start-accept edge and the sampled echo history; a compare process
// checks the DUT against it on each falling clock edge, and the directed
// sequence adds hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_echo_timer;

   localparam int W  = 16;
   localparam int TL = 10;
   localparam int BL = 20;
   localparam int TO = 400;   // short timeout keeps the run small
   localparam int S  = 2;

   logic         clk;
   logic         reset_n;
   logic         start;
   logic         echo_in;
   logic         trigger;
   logic         busy;
   logic         done;
   logic         timeout;
   logic [W-1:0] count;

   int n_checks = 0;
   int n_fails  = 0;
   bit cmp_en   = 0;
   int trig_hi  = 0;
   int cur      = 0;
   bit got_d;
   bit got_t;

   echo_timer #(
      .WIDTH       (W),
      .TRIG_LEN    (TL),
      .BLANK_LEN   (BL),
      .TIMEOUT     (TO),
      .SYNC_STAGES (S)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .echo_in (echo_in),
      .trigger (trigger),
      .busy    (busy),
      .done    (done),
      .timeout (timeout),
      .count   (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Timeline model. m_k is the edge number that accepted start; cnt after
   // edge n is n-m_k. Echo level seen by the edge detector after edge n is
   // the pin sample taken S-1 edges earlier.
   // ------------------------------------------------------------------
   int           n_edge = 0;
   bit           m_idle = 1;
   int           m_k    = 0;
   int           m_rep  = -1;
   bit           m_done = 0;
   bit           m_to   = 0;
   bit           m_trig = 0;
   logic [W-1:0] m_count = '0;
   bit           hist [0:S];   // hist[j] = pin sample from j edges ago
   bit           es_now;
   bit           es_old;
   int           c_prev;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_idle  = 1;
         m_rep   = -1;
         m_done  = 0;
         m_to    = 0;
         m_trig  = 0;
         m_count = '0;
         for (int i = 0; i <= S; i++) hist[i] = 0;
      end else begin
         n_edge++;
         es_now = hist[S-1];
         es_old = hist[S];
         m_done = 0;
         m_to   = 0;
         if (m_idle) begin
            if (start) begin
               m_idle = 0;
               m_k    = n_edge;
               m_rep  = -1;
            end
         end else if (m_rep != -1) begin
            m_idle = 1;
         end else begin
            c_prev = n_edge - 1 - m_k;
            if (c_prev >= TL + BL && es_now && !es_old) begin
               m_done  = 1;
               m_count = W'(c_prev);
               m_rep   = n_edge;
            end else if (c_prev == TO - 1) begin
               m_to    = 1;
               m_count = W'(TO);
               m_rep   = n_edge;
            end
         end
         m_trig = !m_idle && (m_rep == -1) && (n_edge - m_k < TL);
         for (int i = S; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = echo_in;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc_trigger", trigger, m_trig);
         check("cyc_busy",    busy,    !m_idle);
         check("cyc_done",    done,    m_done);
         check("cyc_timeout", timeout, m_to);
         check("cyc_count",   count,   m_count);
      end
   end

   always @(negedge clk) begin
      if (trigger) trig_hi++;
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic launch();
      @(negedge clk);
      start   = 1'b1;
      trig_hi = 0;
      @(posedge clk);
      #1 start = 1'b0;
      cur = 0;
   endtask

   // Leaves the bench just before edge k+d, so a change made now is the
   // first value sampled at edge k+d.
   task automatic advance_to(input int d);
      repeat (d - 1 - cur) @(posedge clk);
      @(negedge clk);
      cur = d - 1;
   endtask

   task automatic wait_pulse(input int limit, output bit gd, output bit gt);
      bit seen;
      seen = 0;
      gd   = 0;
      gt   = 0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         if (done || timeout) begin
            seen = 1;
            gd   = done;
            gt   = timeout;
         end
      end
      if (!seen) begin
         n_checks++;
         n_fails++;
         $display("FAIL wait_pulse: no done/timeout within %0d cycles", limit);
      end
   endtask

   task automatic settle();
      echo_in = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_trigger"}, trigger, 0);
      check({tag, "_busy"},    busy,    0);
      check({tag, "_done"},    done,    0);
      check({tag, "_timeout"}, timeout, 0);
      check({tag, "_count"},   count,   0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   initial begin
      start   = 1'b0;
      echo_in = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      reset_n = 1'b1;
      cmp_en  = 1;
      @(negedge clk);

      // Basic measurement, echo at D=100
      launch();
      advance_to(100);
      echo_in = 1'b1;
      wait_pulse(200, got_d, got_t);
      check("t1_done", got_d, 1);
      check("t1_count", count, 101);
      check("t1_trig_len", trig_hi, TL);
      @(negedge clk);
      check("t1_idle", busy, 0);
      settle();

      // Echo inside blanking is discarded
      launch();
      advance_to(15);
      echo_in = 1'b1;
      advance_to(20);
      echo_in = 1'b0;
      advance_to(200);
      echo_in = 1'b1;
      wait_pulse(200, got_d, got_t);
      check("t2_done", got_d, 1);
      check("t2_count", count, 201);
      @(negedge clk);
      settle();

      // No echo: timeout
      launch();
      wait_pulse(TO + 20, got_d, got_t);
      check("t3_timeout", got_t, 1);
      check("t3_no_done", got_d, 0);
      check("t3_count", count, TO);
      @(negedge clk);
      settle();

      // Edge in the last listening cycle wins over the timeout
      launch();
      advance_to(TO - 2);
      echo_in = 1'b1;
      wait_pulse(40, got_d, got_t);
      check("t3b_done", got_d, 1);
      check("t3b_no_to", got_t, 0);
      check("t3b_count", count, TO - 1);
      @(negedge clk);
      settle();

      // One cycle later the timeout has already fired
      launch();
      advance_to(TO - 1);
      echo_in = 1'b1;
      wait_pulse(40, got_d, got_t);
      check("t3c_timeout", got_t, 1);
      check("t3c_no_done", got_d, 0);
      check("t3c_count", count, TO);
      @(negedge clk);
      settle();

      // start held high, then a stray start pulse during LISTEN
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      cur = 0;
      advance_to(40);
      echo_in = 1'b1;
      wait_pulse(200, got_d, got_t);
      check("t4_done1", got_d, 1);
      check("t4_count1", count, 41);
      @(negedge clk);
      check("t4_idle_gap", busy, 0);
      echo_in = 1'b0;
      @(negedge clk);
      check("t4_restart_trig", trigger, 1);
      check("t4_restart_busy", busy, 1);
      start = 1'b0;
      cur   = 0;
      advance_to(60);
      start = 1'b1;
      advance_to(61);
      start = 1'b0;
      advance_to(80);
      echo_in = 1'b1;
      wait_pulse(200, got_d, got_t);
      check("t4_done2", got_d, 1);
      check("t4_count2", count, 81);
      @(negedge clk);
      @(negedge clk);
      check("t4_no_queue", busy, 0);
      settle();

      // Reset mid-TRIG
      launch();
      advance_to(3);
      check("t5_trig_before", trigger, 1);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("t5_rst_trig");
      @(negedge clk);
      reset_n = 1'b1;
      settle();
      launch();
      advance_to(50);
      echo_in = 1'b1;
      wait_pulse(200, got_d, got_t);
      check("t5_count_a", count, 51);
      @(negedge clk);
      settle();

      // Reset mid-LISTEN
      launch();
      advance_to(100);
      check("t5_busy_before", busy, 1);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("t5_rst_listen");
      @(negedge clk);
      reset_n = 1'b1;
      settle();
      launch();
      advance_to(100);
      echo_in = 1'b1;
      wait_pulse(200, got_d, got_t);
      check("t5_done_b", got_d, 1);
      check("t5_count_b", count, 101);
      @(negedge clk);
      settle();

      // Echo already high when LISTEN begins, then falls and rises
      launch();
      advance_to(12);
      echo_in = 1'b1;
      advance_to(100);
      echo_in = 1'b0;
      advance_to(150);
      echo_in = 1'b1;
      wait_pulse(200, got_d, got_t);
      check("t6_done", got_d, 1);
      check("t6_count", count, 151);
      @(negedge clk);
      settle();

      // Echo already high and stays high: timeout
      launch();
      advance_to(12);
      echo_in = 1'b1;
      wait_pulse(TO + 20, got_d, got_t);
      check("t6b_timeout", got_t, 1);
      check("t6b_no_done", got_d, 0);
      check("t6b_count", count, TO);
      @(negedge clk);
      settle();

      cmp_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_echo_timer
